nn_bus_responder: RTL and testbench
===================================

# nn_bus_responder

Memory-side responder and arbiter for the neuron-calculation bus. It serves up to NREQ neuron calculators that raise `bus_request`. Each request is either a coefficient fetch (`pushout` low) or a neuron-output push (`pushout` high). For a fetch, the block reads CFG_LANES 24-bit words from config memory and presents them packed on `config_data` before granting. For a push, it writes the 24-bit result into data memory in the same cycle as the grant.

## Interface
- NREQ, 4: number of requesters (2..8)
- CFG_LANES, 3: config words fetched per read request (1..8)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- bus_request  in  NREQ  per-requester request, held until granted
- pushout  in  NREQ  request type: 1 = data-memory write, 0 = config read
- config_address  in  NREQ x 8 x 17  per-requester config word addresses; lanes 0..CFG_LANES-1 used
- data_mem_address  in  NREQ x 16  write address (Oloc)
- data_mem_data  in  NREQ x 24  write data (neuron output)
- bus_grant  out  NREQ  one-hot, single-cycle grant pulse
- config_data  out  256  broadcast read data; lane k in [24k+23:24k], bits above 24*CFG_LANES zero
- cfg_rd_en  out  1  config memory read strobe
- cfg_rd_addr  out  17  config memory address
- cfg_rd_data  in  24  config memory data, valid the cycle after cfg_rd_en
- dm_wr_en  out  1  data memory write strobe
- dm_wr_addr  out  16  data memory address
- dm_wr_data  out  24  data memory data

## Operation
- States:
  - IDLE: if any `bus_request` is high, pick the winner round-robin and register its index.
    - Winner has `pushout` = 1: go to WR.
    - Winner has `pushout` = 0: go to RD.
  - RD: issue one read per cycle, lane 0 to CFG_LANES-1: `cfg_rd_en` = 1, `cfg_rd_addr` = `config_address[win][lane]`. After the last lane, go to CAP.
  - CAP: capture the last lane, then go to GRANT. Each lane is captured into the `config_data` register one cycle after it is issued.
  - GRANT: `bus_grant[win]` = 1 for one cycle, `config_data` stable; then go to IDLE.
  - WR: in one cycle, `bus_grant[win]` = 1 and `dm_wr_en` = 1, with `dm_wr_addr`/`dm_wr_data` taken combinationally from the winner's live inputs; then go to IDLE.
- Round-robin: the pointer moves to winner+1 (mod NREQ) after every grant. Search order starts at the pointer.
- `config_data` holds its value until the next read's lane 0 capture. Lanes not yet refetched keep their old values during a fetch.
- Boundary conditions:
  - Winner drops `bus_request` during RD/CAP: the reads complete, GRANT is skipped (no pulse), the block returns to IDLE, and the pointer does not advance.
  - Winner drops `bus_request` in IDLE→WR: no write, no grant.
  - Simultaneous requests: exactly one grant, following the round-robin order.
  - Reset mid-transaction: the transaction is abandoned and no partial write occurs.

## Timing
- Reset values:
  - state IDLE, pointer 0
  - `bus_grant`, `cfg_rd_en`, `dm_wr_en` = 0
  - `cfg_rd_addr`, `dm_wr_addr`, `dm_wr_data` = 0
  - `config_data` = 0
- Request first seen high in IDLE at cycle t:
  - Write: grant and write at t+1. The next arbitration is at t+2, so back-to-back writes get one grant every 2 cycles.
  - Read: `cfg_rd_en` at t+1..t+CFG_LANES; grant at t+CFG_LANES+2 (t+5 for CFG_LANES = 3).
- The requester registers `config_data` on the grant edge and must drop `bus_request` the cycle after the grant.

## Configuration
- NN_RESP_STATS_EN defined:
  - Adds outputs `rd_grants` [15:0] and `wr_grants` [15:0]. These are saturating counters (stick at 16'hFFFF) that increment on each read grant and each write grant.
  - Both reset to 0.
- NN_RESP_STATS_EN undefined: the ports and counters are absent.

## Structure
- Shared package `nn_bus_pkg`:
  - resp_state_t enum (IDLE, RD, CAP, GRANT, WR)
  - widths CFG_AW = 17, DM_AW = 16, DW = 24, CFG_BUS_W = 256
- One sub-module, `rr_arbiter`: NREQ-wide round-robin pointer plus one-hot/index select.

## Test plan
- Single write: requester 2, `pushout` = 1, addr 16'h0040, data 24'h123456 at t → `bus_grant` = 4'b0100 and `dm_wr_en` with those values at t+1; IDLE at t+2.
- Single read:
  - Stimulus: requester 0 with addresses 17'h10, 17'h11, 17'h12; memory returns 24'hA00001/2/3.
  - Response: `cfg_rd_addr` sequence 10/11/12 at t+1..t+3; grant at t+5; `config_data[71:0]` = 24'hA00003_A00002_A00001; upper bits 0.
- Contention: all four requesters write continuously → grants ordered 0, 1, 2, 3, 0, spaced 2 cycles apart.
- Abort: requester 1 read drops `bus_request` at t+2 → no grant pulse, IDLE at t+5, pointer unchanged (requester 1 wins next).
- Reset asserted during RD → all outputs 0 immediately; the next request after release starts cleanly from pointer 0.
- NN_RESP_STATS_EN: 3 reads + 5 writes → `rd_grants` = 3, `wr_grants` = 5; forced to 16'hFFFF, stays at 16'hFFFF after a further grant.

Source files
------------

// File: rtl/nn_bus_pkg.sv
// rtl/nn_bus_pkg.sv - shared types and widths for the neuron-bus responder
package nn_bus_pkg;

  localparam int CFG_AW    = 17;
  localparam int DM_AW     = 16;
  localparam int DW        = 24;
  localparam int CFG_BUS_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    GRANT,
    WR
  } resp_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pointer with one-hot and index winner select
module rr_arbiter
  import nn_bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [IW-1:0]   adv_idx,
  output logic            any_req,
  output logic [IW-1:0]   win_idx,
  output logic [NREQ-1:0] win_onehot
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (adv_idx == IW'(NREQ - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

  // Search starts at the pointer and wraps, so the most recent winner is served last.
  always_comb begin
    int            j;
    logic [IW-1:0] idx;
    any_req    = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      idx = IW'(j);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win_idx = idx;
      end
    end
    win_onehot[win_idx] = any_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/nn_bus_responder.sv
// rtl/nn_bus_responder.sv - memory-side responder/arbiter for the neuron bus
// Optional grant statistics counters enabled by NN_RESP_STATS_EN.
module nn_bus_responder
  import nn_bus_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int CFG_LANES = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREQ-1:0]                   bus_request,
  input  logic [NREQ-1:0]                   pushout,
  input  logic [NREQ-1:0][7:0][CFG_AW-1:0]  config_address,
  input  logic [NREQ-1:0][DM_AW-1:0]        data_mem_address,
  input  logic [NREQ-1:0][DW-1:0]           data_mem_data,
  output logic [NREQ-1:0]                   bus_grant,
  output logic [CFG_BUS_W-1:0]              config_data,
  output logic                              cfg_rd_en,
  output logic [CFG_AW-1:0]                 cfg_rd_addr,
  input  logic [DW-1:0]                     cfg_rd_data,
  output logic                              dm_wr_en,
  output logic [DM_AW-1:0]                  dm_wr_addr,
`ifdef NN_RESP_STATS_EN
  output logic [15:0]                       rd_grants,
  output logic [15:0]                       wr_grants,
`endif
  output logic [DW-1:0]                     dm_wr_data
);

  localparam int IW = $clog2(NREQ);

  resp_state_t          state_q, state_d;
  logic [IW-1:0]        win_q, win_d;
  logic [2:0]           lane_q, lane_d;
  logic [2:0]           cap_lane_q, cap_lane_d;
  logic                 cap_en_q, cap_en_d;
  logic                 abort_q, abort_d;
  logic [CFG_BUS_W-1:0] config_data_q, config_data_d;
  logic                 arb_any, advance;
  logic [IW-1:0]        arb_idx;
  logic [NREQ-1:0]      arb_onehot;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk        (clk),
    .rst_n      (reset),
    .req        (bus_request),
    .advance    (advance),
    .adv_idx    (win_q),
    .any_req    (arb_any),
    .win_idx    (arb_idx),
    .win_onehot (arb_onehot)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    lane_d      = lane_q;
    abort_d     = abort_q;
    advance     = 1'b0;
    bus_grant   = '0;
    cfg_rd_en   = 1'b0;
    cfg_rd_addr = '0;
    dm_wr_en    = 1'b0;
    dm_wr_addr  = '0;
    dm_wr_data  = '0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        lane_d  = '0;
        if (arb_any) begin
          win_d   = arb_idx;
          state_d = (|(pushout & arb_onehot)) ? WR : RD;
        end
      end
      RD: begin
        cfg_rd_en   = 1'b1;
        cfg_rd_addr = config_address[win_q][lane_q];
        abort_d     = abort_q | ~bus_request[win_q];
        if (lane_q == 3'(CFG_LANES - 1)) state_d = CAP;
        else                             lane_d  = lane_q + 3'd1;
      end
      // A requester that let go at any point during the fetch gets no grant.
      CAP: state_d = (bus_request[win_q] && !abort_q) ? GRANT : IDLE;
      GRANT: begin
        bus_grant[win_q] = 1'b1;
        advance          = 1'b1;
        state_d          = IDLE;
      end
      WR: begin
        if (bus_request[win_q]) begin
          bus_grant[win_q] = 1'b1;
          dm_wr_en         = 1'b1;
          dm_wr_addr       = data_mem_address[win_q];
          dm_wr_data       = data_mem_data[win_q];
          advance          = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle after the strobe, so capture trails issue by a cycle.
  always_comb begin
    cap_en_d      = cfg_rd_en;
    cap_lane_d    = lane_q;
    config_data_d = config_data_q;
    if (cap_en_q) config_data_d[cap_lane_q*DW +: DW] = cfg_rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      win_q         <= '0;
      lane_q        <= '0;
      abort_q       <= 1'b0;
      cap_en_q      <= 1'b0;
      cap_lane_q    <= '0;
      config_data_q <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      lane_q        <= lane_d;
      abort_q       <= abort_d;
      cap_en_q      <= cap_en_d;
      cap_lane_q    <= cap_lane_d;
      config_data_q <= config_data_d;
    end
  end

  assign config_data = config_data_q;

`ifdef NN_RESP_STATS_EN
  logic [15:0] rd_grants_q, rd_grants_d, wr_grants_q, wr_grants_d;

  always_comb begin
    rd_grants_d = rd_grants_q;
    wr_grants_d = wr_grants_q;
    if (state_q == GRANT) rd_grants_d = sat_inc16(rd_grants_q);
    if (dm_wr_en)         wr_grants_d = sat_inc16(wr_grants_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_grants_q <= '0;
      wr_grants_q <= '0;
    end else begin
      rd_grants_q <= rd_grants_d;
      wr_grants_q <= wr_grants_d;
    end
  end

  assign rd_grants = rd_grants_q;
  assign wr_grants = wr_grants_q;
`endif

endmodule

// File: tb/tb_nn_bus_responder.sv
// tb/tb_nn_bus_responder.sv - scoreboard bench for nn_bus_responder
module tb_nn_bus_responder;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [3:0]              bus_request;
  logic [3:0]              pushout;
  logic [3:0][7:0][16:0]   config_address;
  logic [3:0][15:0]        data_mem_address;
  logic [3:0][23:0]        data_mem_data;
  logic [3:0]              bus_grant;
  logic [255:0]            config_data;
  logic                    cfg_rd_en;
  logic [16:0]             cfg_rd_addr;
  logic [23:0]             cfg_rd_data = '0;
  logic                    dm_wr_en;
  logic [15:0]             dm_wr_addr;
  logic [23:0]             dm_wr_data;
`ifdef NN_RESP_STATS_EN
  logic [15:0]             rd_grants;
  logic [15:0]             wr_grants;
`endif

  nn_bus_responder #(.NREQ(4), .CFG_LANES(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus_request      (bus_request),
    .pushout          (pushout),
    .config_address   (config_address),
    .data_mem_address (data_mem_address),
    .data_mem_data    (data_mem_data),
    .bus_grant        (bus_grant),
    .config_data      (config_data),
    .cfg_rd_en        (cfg_rd_en),
    .cfg_rd_addr      (cfg_rd_addr),
    .cfg_rd_data      (cfg_rd_data),
    .dm_wr_en         (dm_wr_en),
    .dm_wr_addr       (dm_wr_addr),
`ifdef NN_RESP_STATS_EN
    .rd_grants        (rd_grants),
    .wr_grants        (wr_grants),
`endif
    .dm_wr_data       (dm_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  grant;
    bit          wr;
    logic [15:0] addr;
    logic [23:0] data;
    logic [71:0] cfg;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         grant_cnt = 0;
  logic [3:0] last_grant = '0;
  logic [3:0] reraise = '0;
  int         remaining[4];

  function automatic logic [23:0] mem_word(input logic [16:0] a);
    return 24'hA00000 + 24'(a) - 24'h00000F;
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input bit wr, input logic [15:0] a,
                              input logic [23:0] d, input logic [71:0] cfg, input int c);
    exp_t e;
    e.grant = g; e.wr = wr; e.addr = a; e.data = d; e.cfg = cfg; e.cyc = c;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (cfg_rd_en) cfg_rd_data <= mem_word(cfg_rd_addr);

  always @(negedge clk) begin
    exp_t e;
    last_grant = bus_grant;
    if (bus_grant !== 4'b0) begin
      grant_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_grant", 256'(bus_grant), 256'd0);
      end else begin
        e = sb.pop_front();
        check_eq("grant", 256'(bus_grant), 256'(e.grant));
        check_eq("grant_cycle", 256'(cyc), 256'(e.cyc));
        if (e.wr) begin
          check_eq("wr_en", 256'(dm_wr_en), 256'd1);
          check_eq("wr_addr", 256'(dm_wr_addr), 256'(e.addr));
          check_eq("wr_data", 256'(dm_wr_data), 256'(e.data));
        end else begin
          check_eq("rd_no_wr", 256'(dm_wr_en), 256'd0);
          check_eq("cfg_lanes", 256'(config_data[71:0]), 256'(e.cfg));
          check_eq("cfg_upper", 256'(config_data[255:72]), 256'd0);
        end
      end
    end else if (dm_wr_en) begin
      check_eq("stray_write", 256'(dm_wr_en), 256'd0);
    end
  end

  // Requester behaviour: drop the cycle after a grant, optionally re-raise one cycle later.
  task automatic tick();
    @(posedge clk);
    #1;
    bus_request = bus_request | reraise;
    reraise = '0;
    for (int i = 0; i < 4; i++) begin
      if (last_grant[i]) begin
        bus_request[i] = 1'b0;
        if (remaining[i] > 0) begin
          remaining[i]--;
          reraise[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("sb_drain", 256'(sb.size()), 256'd0);
    sb.delete();
  endtask

  task automatic set_lanes(input int r, input logic [16:0] base);
    for (int k = 0; k < 3; k++) config_address[r][k] = base + 17'(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int gc;
    logic [16:0] b;
    reset            = 1'b0;
    bus_request      = '0;
    pushout          = '0;
    config_address   = '0;
    data_mem_address = '0;
    data_mem_data    = '0;
    for (int i = 0; i < 4; i++) remaining[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 256'(bus_grant), 256'd0);
    check_eq("rst_rd_en", 256'(cfg_rd_en), 256'd0);
    check_eq("rst_wr_en", 256'(dm_wr_en), 256'd0);
    check_eq("rst_rd_addr", 256'(cfg_rd_addr), 256'd0);
    check_eq("rst_wr_addr", 256'(dm_wr_addr), 256'd0);
    check_eq("rst_wr_data", 256'(dm_wr_data), 256'd0);
    check_eq("rst_cfg", config_data, 256'd0);
    reset = 1'b1;
    tick();

    // single write from requester 2
    data_mem_address[2] = 16'h0040;
    data_mem_data[2]    = 24'h123456;
    pushout[2]          = 1'b1;
    bus_request[2]      = 1'b1;
    sb.push_back(mk(4'b0100, 1'b1, 16'h0040, 24'h123456, '0, cyc + 1));
    drain(20);
    check_eq("wr_then_idle", 256'(bus_grant), 256'd0);

    // single read from requester 0
    tick();
    set_lanes(0, 17'h10);
    pushout[0]     = 1'b0;
    bus_request[0] = 1'b1;
    c = cyc;
    sb.push_back(mk(4'b0001, 1'b0, '0, '0, {24'hA00003, 24'hA00002, 24'hA00001}, c + 5));
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rd_en", 256'(cfg_rd_en), 256'd1);
      check_eq("rd_addr", 256'(cfg_rd_addr), 256'(17'h10 + 17'(k)));
    end
    tick();
    check_eq("rd_en_cap", 256'(cfg_rd_en), 256'd0);
    drain(20);

    // requester 1 aborts a read mid-fetch
    tick();
    set_lanes(1, 17'h20);
    pushout[1]     = 1'b0;
    bus_request[1] = 1'b1;
    gc = grant_cnt;
    tick();
    tick();
    bus_request[1] = 1'b0;
    tick();
    check_eq("abort_reads_continue", 256'(cfg_rd_en), 256'd1);
    repeat (4) tick();
    check_eq("abort_no_grant", 256'(grant_cnt), 256'(gc));

    // pointer stayed at 1: with 1 and 2 both writing, 1 goes first
    data_mem_address[1] = 16'h0011;
    data_mem_data[1]    = 24'hABCDEF;
    pushout[1]          = 1'b1;
    c = cyc;
    bus_request[1] = 1'b1;
    bus_request[2] = 1'b1;
    sb.push_back(mk(4'b0010, 1'b1, 16'h0011, 24'hABCDEF, '0, c + 1));
    sb.push_back(mk(4'b0100, 1'b1, 16'h0040, 24'h123456, '0, c + 3));
    drain(20);

    // reset in the middle of a read
    tick();
    set_lanes(3, 17'h30);
    pushout[3]     = 1'b0;
    bus_request[3] = 1'b1;
    tick();
    tick();
    check_eq("pre_reset_rd_en", 256'(cfg_rd_en), 256'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_rd_en", 256'(cfg_rd_en), 256'd0);
    check_eq("mid_rst_rd_addr", 256'(cfg_rd_addr), 256'd0);
    check_eq("mid_rst_grant", 256'(bus_grant), 256'd0);
    check_eq("mid_rst_wr_en", 256'(dm_wr_en), 256'd0);
    check_eq("mid_rst_cfg", config_data, 256'd0);
    bus_request = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // all four write continuously from pointer 0
    for (int i = 0; i < 4; i++) begin
      data_mem_address[i] = 16'h0100 + 16'(i);
      data_mem_data[i]    = 24'hD00000 + 24'(i);
    end
    pushout      = 4'hF;
    remaining[0] = 1;
    c = cyc;
    bus_request = 4'hF;
    sb.push_back(mk(4'b0001, 1'b1, 16'h0100, 24'hD00000, '0, c + 1));
    sb.push_back(mk(4'b0010, 1'b1, 16'h0101, 24'hD00001, '0, c + 3));
    sb.push_back(mk(4'b0100, 1'b1, 16'h0102, 24'hD00002, '0, c + 5));
    sb.push_back(mk(4'b1000, 1'b1, 16'h0103, 24'hD00003, '0, c + 7));
    sb.push_back(mk(4'b0001, 1'b1, 16'h0100, 24'hD00000, '0, c + 9));
    drain(40);

    // three back-to-back single reads
    for (int r = 0; r < 3; r++) begin
      tick();
      b = 17'h40 + 17'(r * 4);
      set_lanes(r, b);
      pushout[r]     = 1'b0;
      bus_request[r] = 1'b1;
      c = cyc;
      sb.push_back(mk(4'(1 << r), 1'b0, '0, '0,
                      {mem_word(b + 17'd2), mem_word(b + 17'd1), mem_word(b)}, c + 5));
      drain(20);
    end

`ifdef NN_RESP_STATS_EN
    check_eq("stat_rd", 256'(rd_grants), 256'd3);
    check_eq("stat_wr", 256'(wr_grants), 256'd5);
    force dut.rd_grants_q = 16'hFFFF;
    force dut.wr_grants_q = 16'hFFFF;
    #1;
    release dut.rd_grants_q;
    release dut.wr_grants_q;
    tick();
    pushout[3]     = 1'b1;
    bus_request[3] = 1'b1;
    sb.push_back(mk(4'b1000, 1'b1, 16'h0103, 24'hD00003, '0, cyc + 1));
    drain(20);
    tick();
    set_lanes(0, 17'h10);
    pushout[0]     = 1'b0;
    bus_request[0] = 1'b1;
    sb.push_back(mk(4'b0001, 1'b0, '0, '0, {24'hA00003, 24'hA00002, 24'hA00001}, cyc + 5));
    drain(20);
    check_eq("stat_rd_sat", 256'(rd_grants), 256'hFFFF);
    check_eq("stat_wr_sat", 256'(wr_grants), 256'hFFFF);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
